// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared state encoding and default widths for the core run
// controller and its step down-counter.
package core_ctrl_pkg;

  localparam int STEP_W_DEF = 16;
  localparam int CNT_W_DEF  = 32;

  // 2'b11 is not a legal state; the controller recovers from it to HALT.
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  // State the controller leaves reset in.
  function automatic state_e reset_state(input bit run_after_reset);
    return run_after_reset ? ST_RUN : ST_HALT;
  endfunction

endpackage

// File: rtl/core_ctrl_step_cnt.sv
// core_ctrl_step_cnt: loadable down-counter holding the number of enabled
// cycles left in a step sequence. last_o marks the final cycle of the step.
module core_ctrl_step_cnt
  import core_ctrl_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [STEP_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              last_o
);

  logic [STEP_W-1:0] count_q;
  logic [STEP_W-1:0] count_d;

  // An abort clears the count, a new step loads it, otherwise count down to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - STEP_W'(1);
    end
  end

  // Remaining-cycle register, zeroed by reset so a step is aborted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == STEP_W'(1));

endmodule

// File: rtl/core_run_controller.sv
// core_run_controller: run/halt/single-step sequencer producing the single
// clock-enable that advances the PC and all pipeline register banks together.
// Build option CORE_CTRL_BP_EN enables the PC breakpoint; without it the
// breakpoint ports are accepted but ignored and bp_hit_o stays low.
module core_run_controller
  import core_ctrl_pkg::*;
#(
  parameter int STEP_W    = STEP_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter bit RESET_RUN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_run_i,
  input  logic              cmd_halt_i,
  input  logic              cmd_step_i,
  input  logic [STEP_W-1:0] step_num_i,
  input  logic              bp_valid_i,
  input  logic [31:0]       bp_addr_i,
  input  logic [31:0]       pc_i,
  output logic              core_en_o,
  output logic              halted_o,
  output logic              bp_hit_o,
  output logic              step_done_o,
  output logic [CNT_W-1:0]  cycle_count_o
);

  localparam state_e RESET_STATE = reset_state(RESET_RUN);

  state_e           state_q;
  logic             halted_q;
  logic             step_done_q;
  logic [CNT_W-1:0] cycle_count_q;

  logic bp_match;
  logic core_en;
  logic start_step;
  logic start_run;
  logic step_last;
  logic step_abort;

  // In HALT, halt blocks everything, a non-zero step beats run.
  assign start_step = (state_q == ST_HALT) && cmd_step_i && !cmd_halt_i &&
                      (step_num_i != '0);
  assign start_run  = (state_q == ST_HALT) && cmd_run_i && !cmd_halt_i && !start_step;
  assign step_abort = (state_q == ST_STEP) && cmd_halt_i;

  assign core_en = ((state_q == ST_RUN) && !bp_match) || (state_q == ST_STEP);

`ifdef CORE_CTRL_BP_EN
  logic skip_q;
  logic bp_hit_q;

  // skip lets a resumed core execute past the breakpoint address once.
  assign bp_match = bp_valid_i && (pc_i == bp_addr_i) && !skip_q;

  // Arm skip and clear bp_hit on resume; record a breakpoint stop as sticky.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skip_q   <= 1'b0;
      bp_hit_q <= 1'b0;
    end else if (start_step || start_run) begin
      skip_q   <= 1'b1;
      bp_hit_q <= 1'b0;
    end else begin
      if (core_en) begin
        skip_q <= 1'b0;
      end
      if ((state_q == ST_RUN) && bp_match) begin
        bp_hit_q <= 1'b1;
      end
    end
  end

  assign bp_hit_o = bp_hit_q;
`else
  logic unused_bp;

  assign bp_match  = 1'b0;
  assign unused_bp = bp_valid_i ^ (^bp_addr_i) ^ (^pc_i);
  assign bp_hit_o  = 1'b0;
`endif

  core_ctrl_step_cnt #(
    .STEP_W (STEP_W)
  ) u_step_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (step_abort),
    .load_i     (start_step),
    .load_val_i (step_num_i),
    .dec_i      (state_q == ST_STEP),
    .last_o     (step_last)
  );

  // Run/halt/step state machine with registered halted and step_done flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RESET_STATE;
      halted_q    <= (RESET_STATE == ST_HALT);
      step_done_q <= 1'b0;
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        ST_HALT: begin
          if (start_step) begin
            state_q  <= ST_STEP;
            halted_q <= 1'b0;
          end else if (start_run) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bp_match || cmd_halt_i) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_STEP: begin
          if (cmd_halt_i) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (step_last) begin
            state_q     <= ST_HALT;
            halted_q    <= 1'b1;
            step_done_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // Count every enabled cycle, wrapping at the counter width.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_count_q <= '0;
    end else if (core_en) begin
      cycle_count_q <= cycle_count_q + CNT_W'(1);
    end
  end

  assign core_en_o     = core_en;
  assign halted_o      = halted_q;
  assign step_done_o   = step_done_q;
  assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller: drives two controllers (one leaving reset halted
// with a 32-bit counter, one leaving reset running with a 4-bit counter so
// wrap-around is reached quickly) from shared inputs and compares them against
// a behavioural model kept in the bench.
module tb_core_run_controller;

  localparam int STEP_W = 16;
`ifdef CORE_CTRL_BP_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cmdRun;
  logic              cmdHalt;
  logic              cmdStep;
  logic [STEP_W-1:0] stepNum;
  logic              bpValid;
  logic [31:0]       bpAddr;
  logic [31:0]       pc;

  logic        coreEn0, halted0, bpHit0, stepDone0;
  logic [31:0] cycleCount0;
  logic        coreEn1, halted1, bpHit1, stepDone1;
  logic [3:0]  cycleCount1;

  bit pcFollow;
  int testsRun    = 0;
  int testsFailed = 0;

  // Model: per instance, running flag, steps still owed, skip, sticky bp, counter.
  bit     mRunning[2];
  int     mStepsLeft[2];
  bit     mSkip[2];
  bit     mBpHit[2];
  bit     mStepDone[2];
  longint mCount[2];
  longint mCountMod[2];

  // Period-10 free-running clock.
  always #5 clk = ~clk;

  core_run_controller #(.STEP_W(STEP_W), .CNT_W(32), .RESET_RUN(1'b0)) dutHalt (
    .clk_i(clk), .rst_i(rst), .cmd_run_i(cmdRun), .cmd_halt_i(cmdHalt),
    .cmd_step_i(cmdStep), .step_num_i(stepNum), .bp_valid_i(bpValid),
    .bp_addr_i(bpAddr), .pc_i(pc), .core_en_o(coreEn0), .halted_o(halted0),
    .bp_hit_o(bpHit0), .step_done_o(stepDone0), .cycle_count_o(cycleCount0)
  );

  core_run_controller #(.STEP_W(STEP_W), .CNT_W(4), .RESET_RUN(1'b1)) dutRun (
    .clk_i(clk), .rst_i(rst), .cmd_run_i(cmdRun), .cmd_halt_i(cmdHalt),
    .cmd_step_i(cmdStep), .step_num_i(stepNum), .bp_valid_i(bpValid),
    .bp_addr_i(bpAddr), .pc_i(pc), .core_en_o(coreEn1), .halted_o(halted1),
    .bp_hit_o(bpHit1), .step_done_o(stepDone1), .cycle_count_o(cycleCount1)
  );

  function automatic bit modelBpMatch(input int i);
    return BP_EN && bpValid && (pc == bpAddr) && !mSkip[i];
  endfunction

  function automatic bit modelEnable(input int i);
    return (mRunning[i] && !modelBpMatch(i)) || (mStepsLeft[i] > 0);
  endfunction

  function automatic bit modelHalted(input int i);
    return !mRunning[i] && (mStepsLeft[i] == 0);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mRunning[i]   = (i == 1);
      mStepsLeft[i] = 0;
      mSkip[i]      = 1'b0;
      mBpHit[i]     = 1'b0;
      mStepDone[i]  = 1'b0;
      mCount[i]     = 0;
    end
    mCountMod[0] = 64'h1_0000_0000;
    mCountMod[1] = 16;
  endtask

  // One clock edge of the controller's rules, using the inputs of that cycle.
  task automatic modelAdvance();
    for (int i = 0; i < 2; i++) begin
      bit en;
      bit bpm;
      en  = modelEnable(i);
      bpm = modelBpMatch(i);
      mStepDone[i] = 1'b0;
      if (en) begin
        mSkip[i]  = 1'b0;
        mCount[i] = (mCount[i] + 1) % mCountMod[i];
      end
      if (mStepsLeft[i] > 0) begin
        if (cmdHalt) begin
          mStepsLeft[i] = 0;
        end else begin
          mStepsLeft[i]--;
          if (mStepsLeft[i] == 0) mStepDone[i] = 1'b1;
        end
      end else if (mRunning[i]) begin
        if (bpm) begin
          mRunning[i] = 1'b0;
          mBpHit[i]   = 1'b1;
        end else if (cmdHalt) begin
          mRunning[i] = 1'b0;
        end
      end else if (!cmdHalt) begin
        if (cmdStep && (stepNum != 0)) begin
          mStepsLeft[i] = int'(stepNum);
          mSkip[i]      = 1'b1;
          mBpHit[i]     = 1'b0;
        end else if (cmdRun) begin
          mRunning[i] = 1'b1;
          mSkip[i]    = 1'b1;
          mBpHit[i]   = 1'b0;
        end
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic checkOutput(input string tag);
    checkValue({tag, ".coreEn0"},   64'(coreEn0),     64'(modelEnable(0)));
    checkValue({tag, ".halted0"},   64'(halted0),     64'(modelHalted(0)));
    checkValue({tag, ".bpHit0"},    64'(bpHit0),      64'(mBpHit[0]));
    checkValue({tag, ".stepDone0"}, 64'(stepDone0),   64'(mStepDone[0]));
    checkValue({tag, ".count0"},    64'(cycleCount0), 64'(mCount[0]));
    checkValue({tag, ".coreEn1"},   64'(coreEn1),     64'(modelEnable(1)));
    checkValue({tag, ".halted1"},   64'(halted1),     64'(modelHalted(1)));
    checkValue({tag, ".bpHit1"},    64'(bpHit1),      64'(mBpHit[1]));
    checkValue({tag, ".stepDone1"}, 64'(stepDone1),   64'(mStepDone[1]));
    checkValue({tag, ".count1"},    64'(cycleCount1), 64'(mCount[1]));
  endtask

  // Check just after the falling edge, then let one rising edge happen.
  task automatic tick(input string tag);
    bit advPc;
    #1;
    checkOutput(tag);
    advPc = pcFollow && modelEnable(1);
    @(posedge clk);
    if (!rst) modelAdvance();
    @(negedge clk);
    if (advPc) pc = (pc + 32'd4) & 32'h1F;
  endtask

  task automatic applyStimulus(input string tag, input bit run, input bit halt,
                               input bit step, input int num);
    cmdRun  = run;
    cmdHalt = halt;
    cmdStep = step;
    stepNum = STEP_W'(num);
    tick(tag);
    cmdRun  = 1'b0;
    cmdHalt = 1'b0;
    cmdStep = 1'b0;
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput({tag, ".async"});
    @(negedge clk);
    checkOutput({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] countBefore;
    cmdRun = 1'b0; cmdHalt = 1'b0; cmdStep = 1'b0; stepNum = '0;
    bpValid = 1'b0; bpAddr = 32'h10; pc = '0; pcFollow = 1'b0;
    applyReset("reset");

    // Step of three from HALT.
    applyStimulus("s1Cmd", 1'b0, 1'b0, 1'b1, 3);
    for (int i = 0; i < 5; i++) tick("s1Run");
    checkValue("s1Count", 64'(cycleCount0), 64'd3);
    checkValue("s1Halted", 64'(halted0), 64'd1);

    // Breakpoint stop while free-running, then resume past it and wrap back.
    applyReset("s2Reset");
    bpValid = 1'b1; bpAddr = 32'h10; pc = '0; pcFollow = 1'b1;
    for (int i = 0; i < 6; i++) tick("s2Bp");
    applyStimulus("s3Resume", 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 12; i++) tick("s3Run");

    // Halt beats step; a zero-length step is ignored.
    pcFollow = 1'b0; bpValid = 1'b0;
    applyStimulus("s4Stop", 1'b0, 1'b1, 1'b0, 0);
    applyStimulus("s4HaltStep", 1'b0, 1'b1, 1'b1, 5);
    tick("s4Idle");
    checkValue("s4Halted", 64'(halted0), 64'd1);
    applyStimulus("s4ZeroStep", 1'b0, 1'b0, 1'b1, 0);
    tick("s4Idle2");
    checkValue("s4ZeroHalted", 64'(halted0), 64'd1);

    // Step of ten aborted by halt on its fourth enabled cycle.
    countBefore = cycleCount0;
    applyStimulus("s5Cmd", 1'b0, 1'b0, 1'b1, 10);
    for (int i = 0; i < 3; i++) tick("s5Step");
    applyStimulus("s5Abort", 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) tick("s5After");
    checkValue("s5Enabled", 64'(cycleCount0 - countBefore), 64'd4);

    // Asynchronous reset with seven cycles of a step still owed.
    applyStimulus("s6Cmd", 1'b0, 1'b0, 1'b1, 10);
    for (int i = 0; i < 3; i++) tick("s6Step");
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("s6AsyncReset");
    @(negedge clk);
    rst = 1'b0;

    // Free-run long enough for the 4-bit counter to wrap to zero.
    for (int i = 0; i < 16; i++) tick("s6Wrap");
    checkValue("s6WrapCount", 64'(cycleCount1), 64'd0);

    // Randomised commands, step lengths and breakpoint arming.
    pc = '0; pcFollow = 1'b1; bpAddr = 32'h10;
    for (int n = 0; n < 400; n++) begin
      int r;
      r       = int'($urandom_range(0, 99));
      cmdRun  = (r < 6);
      cmdHalt = (r >= 6) && (r < 10);
      cmdStep = (r >= 10) && (r < 20);
      if ($urandom_range(0, 19) == 0) cmdHalt = 1'b1;
      if ($urandom_range(0, 19) == 0) cmdRun = 1'b1;
      stepNum = STEP_W'($urandom_range(0, 6));
      bpValid = ($urandom_range(0, 3) != 0);
      tick("rand");
    end
    cmdRun = 1'b0; cmdHalt = 1'b0; cmdStep = 1'b0;
    tick("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
